// File: rtl/power_mode_pkg.sv
// Shared state encoding and widths for the power-mode controller.
package power_mode_pkg;

    localparam int STATE_W = 3;

    // The first four codes keep the legacy 2-bit encodings.
    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 3'b000,
        ST_NORMAL    = 3'b001,
        ST_LOW_POWER = 3'b010,
        ST_SLEEP     = 3'b011,
        ST_DRAIN     = 3'b100,
        ST_WAKE      = 3'b101
    } state_t;

endpackage

// File: rtl/power_mode_ctrl_solar_debounce.sv
// Two-flop synchroniser and debounce filter for the raw solar-good comparator.
module solar_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic solar_on,
    output logic solar_ok
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous comparator output into the clk domain.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= solar_on;
            sync_2 <= sync_1;
        end
    end

    // Toggle solar_ok only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            solar_ok <= 1'b0;
        end else if (sync_2 == solar_ok) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt      <= '0;
            solar_ok <= ~solar_ok;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/power_mode_ctrl.sv
// Power-mode sequencer: filters solar-good, handshakes loads before sleep,
// and holds rails for a settle time on wake.
module power_mode_ctrl
    import power_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DRAIN_TIMEOUT   = 8,
    parameter int WAKE_DELAY      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               solar_on,
    input  logic               always_on,
    input  logic               low_power,
    input  logic               loads_idle,
    output logic [STATE_W-1:0] state,
    output logic               sleep_req,
    output logic               power_gate_en,
    output logic               low_power_en,
    output logic               mode_valid,
    output logic               drain_timeout
);

    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int WAKE_W  = $clog2(WAKE_DELAY + 1);

    state_t             state_q;
    state_t             state_d;
    state_t             active_mode;
    logic               solar_ok;
    logic               timeout_d;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [WAKE_W-1:0]  wake_cnt;

    solar_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_solar_debounce (
        .clk      (clk),
        .reset    (reset),
        .solar_on (solar_on),
        .solar_ok (solar_ok)
    );

    // State register, dwell counters and the registered timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RESET;
            drain_cnt     <= '0;
            wake_cnt      <= '0;
            drain_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt     <= (state_q == ST_DRAIN && state_d == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            wake_cnt      <= (state_q == ST_WAKE && state_d == ST_WAKE) ? wake_cnt + WAKE_W'(1) : '0;
            drain_timeout <= timeout_d;
        end
    end

    // Next-state logic; DRAIN checks abort, then loads_idle, then timeout.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d     = state_q;
        timeout_d   = 1'b0;
        active_mode = low_power ? ST_LOW_POWER : ST_NORMAL;
        case (state_q)
            ST_RESET: begin
                if (solar_ok) state_d = active_mode;
            end
            ST_NORMAL, ST_LOW_POWER: begin
                if (!solar_ok && !always_on)   state_d = ST_DRAIN;
                else if (state_q != active_mode) state_d = active_mode;
            end
            ST_DRAIN: begin
                if (solar_ok || always_on) begin
                    state_d = active_mode;
                end else if (loads_idle) begin
                    state_d = ST_SLEEP;
                end else if (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d   = ST_SLEEP;
                    timeout_d = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (solar_ok) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                if (!solar_ok && !always_on)               state_d = ST_SLEEP;
                else if (wake_cnt == WAKE_W'(WAKE_DELAY - 1)) state_d = active_mode;
            end
            // Unused codes recover through RESET.
            default: state_d = ST_RESET;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        sleep_req     = (state_q == ST_DRAIN);
        power_gate_en = (state_q == ST_SLEEP);
        low_power_en  = (state_q == ST_LOW_POWER);
        mode_valid    = (state_q == ST_NORMAL) || (state_q == ST_LOW_POWER);
    end

    assign state = state_q;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Directed self-checking bench for power_mode_ctrl with default parameters.
module tb_power_mode_ctrl;

    logic       clk;
    logic       reset;
    logic       solar_on;
    logic       always_on;
    logic       low_power;
    logic       loads_idle;
    logic [2:0] state;
    logic       sleep_req;
    logic       power_gate_en;
    logic       low_power_en;
    logic       mode_valid;
    logic       drain_timeout;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] S_RESET = 3'b000;
    localparam logic [2:0] S_NORM  = 3'b001;
    localparam logic [2:0] S_LP    = 3'b010;
    localparam logic [2:0] S_SLEEP = 3'b011;
    localparam logic [2:0] S_DRAIN = 3'b100;
    localparam logic [2:0] S_WAKE  = 3'b101;

    power_mode_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .solar_on      (solar_on),
        .always_on     (always_on),
        .low_power     (low_power),
        .loads_idle    (loads_idle),
        .state         (state),
        .sleep_req     (sleep_req),
        .power_gate_en (power_gate_en),
        .low_power_en  (low_power_en),
        .mode_valid    (mode_valid),
        .drain_timeout (drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " state"}, 32'(state), 32'(S_RESET));
        check({tag, " sleep_req"}, 32'(sleep_req), 0);
        check({tag, " power_gate_en"}, 32'(power_gate_en), 0);
        check({tag, " low_power_en"}, 32'(low_power_en), 0);
        check({tag, " mode_valid"}, 32'(mode_valid), 0);
        check({tag, " drain_timeout"}, 32'(drain_timeout), 0);
    endtask

    initial begin
        reset      = 1'b1;
        solar_on   = 1'b1;
        always_on  = 1'b0;
        low_power  = 1'b0;
        loads_idle = 1'b0;
        tick(2);
        check_all_zero("reset");

        // 1: power-up with solar present.
        reset = 1'b0;
        tick(6);
        check("p1 solar_ok rise", 32'(dut.u_solar_debounce.solar_ok), 1);
        check("p1 still reset", 32'(state), 32'(S_RESET));
        tick(1);
        check("p1 normal", 32'(state), 32'(S_NORM));
        check("p1 mode_valid", 32'(mode_valid), 1);

        // 2: three-cycle glitch is filtered.
        solar_on = 1'b0;
        tick(3);
        solar_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("p2 glitch solar_ok", 32'(dut.u_solar_debounce.solar_ok), 1);
            check("p2 glitch state", 32'(state), 32'(S_NORM));
        end

        // 3: drain acknowledged by loads_idle.
        solar_on = 1'b0;
        tick(6);
        check("p3 pre-drain", 32'(state), 32'(S_NORM));
        tick(1);
        check("p3 drain", 32'(state), 32'(S_DRAIN));
        check("p3 sleep_req", 32'(sleep_req), 1);
        tick(2);
        check("p3 drain hold", 32'(state), 32'(S_DRAIN));
        loads_idle = 1'b1;
        tick(1);
        check("p3 sleep", 32'(state), 32'(S_SLEEP));
        check("p3 power_gate_en", 32'(power_gate_en), 1);
        check("p3 no timeout", 32'(drain_timeout), 0);
        check("p3 sleep_req off", 32'(sleep_req), 0);
        loads_idle = 1'b0;

        // 5a: wake into LOW_POWER after six settle cycles.
        low_power = 1'b1;
        solar_on  = 1'b1;
        tick(6);
        check("p5 still sleep", 32'(state), 32'(S_SLEEP));
        tick(1);
        check("p5 wake", 32'(state), 32'(S_WAKE));
        check("p5 gate off", 32'(power_gate_en), 0);
        tick(5);
        check("p5 wake last", 32'(state), 32'(S_WAKE));
        tick(1);
        check("p5 low_power", 32'(state), 32'(S_LP));
        check("p5 low_power_en", 32'(low_power_en), 1);
        check("p5 mode_valid", 32'(mode_valid), 1);

        // 4: drain times out after exactly eight cycles.
        solar_on = 1'b0;
        tick(7);
        check("p4 drain", 32'(state), 32'(S_DRAIN));
        tick(7);
        check("p4 drain cycle 8", 32'(state), 32'(S_DRAIN));
        check("p4 no early pulse", 32'(drain_timeout), 0);
        tick(1);
        check("p4 sleep", 32'(state), 32'(S_SLEEP));
        check("p4 timeout pulse", 32'(drain_timeout), 1);
        tick(1);
        check("p4 pulse one cycle", 32'(drain_timeout), 0);

        // 5b: solar lost during WAKE returns to SLEEP.
        solar_on = 1'b1;
        tick(4);
        solar_on = 1'b0;
        tick(3);
        check("p5b wake", 32'(state), 32'(S_WAKE));
        tick(3);
        check("p5b wake cycle 4", 32'(state), 32'(S_WAKE));
        tick(1);
        check("p5b back to sleep", 32'(state), 32'(S_SLEEP));
        check("p5b gate on", 32'(power_gate_en), 1);

        // 6a: reset asserted in DRAIN.
        low_power = 1'b0;
        solar_on  = 1'b1;
        tick(13);
        check("p6 normal", 32'(state), 32'(S_NORM));
        solar_on = 1'b0;
        tick(7);
        check("p6 drain", 32'(state), 32'(S_DRAIN));
        #3 reset = 1'b1;
        #1 check_all_zero("p6 reset in drain");
        tick(1);
        reset = 1'b0;

        // loads_idle and timeout together: loads_idle wins, no pulse.
        solar_on = 1'b1;
        tick(7);
        check("p6 normal again", 32'(state), 32'(S_NORM));
        solar_on = 1'b0;
        tick(7);
        check("p6 drain again", 32'(state), 32'(S_DRAIN));
        tick(7);
        loads_idle = 1'b1;
        tick(1);
        check("p6 tie sleep", 32'(state), 32'(S_SLEEP));
        check("p6 tie no pulse", 32'(drain_timeout), 0);
        loads_idle = 1'b0;

        // 6b: reset asserted in WAKE.
        solar_on = 1'b1;
        tick(7);
        check("p6 wake", 32'(state), 32'(S_WAKE));
        tick(1);
        #3 reset = 1'b1;
        #1 check_all_zero("p6 reset in wake");
        tick(1);
        reset = 1'b0;

        // 6c: always_on holds the mode with solar gone.
        tick(7);
        check("p6c normal", 32'(state), 32'(S_NORM));
        always_on = 1'b1;
        solar_on  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("p6c hold", 32'(state), 32'(S_NORM));
            check("p6c no drain", 32'(sleep_req), 0);
        end
        low_power = 1'b1;
        tick(1);
        check("p6c switch to lp", 32'(state), 32'(S_LP));
        check("p6c low_power_en", 32'(low_power_en), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
